// File: rtl/prll_bs_rbtr_rr_n_drvrs.sv
// Round-robin single-bus arbiter and packet router for N driver FIFOs.
// Moves one packet per grant with broadcast, backpressure and stall timeout.
module prll_bs_rbtr_rr_n_drvrs #(
  parameter int              bits      = 256,
  parameter int              drvrs     = 6,
  parameter int              id_w      = 8,
  parameter logic [id_w-1:0] broadcast = {id_w{1'b1}},
  parameter int              timeout   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [drvrs-1:0]      pndng,
  input  logic [drvrs*bits-1:0] D_pop,
  input  logic [drvrs-1:0]      full,
  output logic [drvrs-1:0]      pop,
  output logic [drvrs-1:0]      push,
  output logic [drvrs*bits-1:0] D_push,
  output logic                  drop,
  output logic                  busy
);

  localparam int ptr_w = $clog2(drvrs);
  localparam int cnt_w = (timeout > 1) ? $clog2(timeout) : 1;
  localparam logic [cnt_w-1:0] tmax =
    cnt_w'((timeout > 0) ? timeout - 1 : 0);

  typedef enum logic {
    IDLE,
    PUSH
  } state_t;

  state_t           state;
  logic [ptr_w-1:0] last;
  logic [cnt_w-1:0] cnt;
  logic [bits-1:0]  pkt;

  logic [ptr_w-1:0] win;
  logic             found;
  logic [id_w-1:0]  dst;
  logic [drvrs-1:0] mask;
  logic             blocked;
  logic             expired;

  // Search starts one past the last winner, wrapping at drvrs.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= drvrs; k++) begin
      idx = int'(last) + k;
      if (idx >= drvrs) begin
        idx = idx - drvrs;
      end
      if (!found && pndng[idx]) begin
        found = 1'b1;
        win   = ptr_w'(idx);
      end
    end
  end

  assign dst = pkt[bits-1 -: id_w];

  // Broadcast skips the source; a unicast may loop back to it.
  always_comb begin
    mask = '0;
    if (dst == broadcast) begin
      for (int i = 0; i < drvrs; i++) begin
        mask[i] = (last != ptr_w'(i));
      end
    end else begin
      for (int i = 0; i < drvrs; i++) begin
        mask[i] = (int'(dst) == i);
      end
    end
  end

  assign blocked = |(mask & full);
  assign expired = (timeout != 0) && (cnt == tmax);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      last   <= ptr_w'(drvrs - 1);
      cnt    <= '0;
      pkt    <= '0;
      pop    <= '0;
      push   <= '0;
      D_push <= '0;
      drop   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      pop  <= '0;
      push <= '0;
      drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            pkt   <= D_pop[win*bits +: bits];
            pop   <= {{(drvrs-1){1'b0}}, 1'b1} << win;
            last  <= win;
            cnt   <= '0;
            state <= PUSH;
            busy  <= 1'b1;
          end
        end
        PUSH: begin
          if (mask == '0) begin
            drop  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!blocked) begin
            push   <= mask;
            D_push <= {drvrs{pkt}};
            state  <= IDLE;
            busy   <= 1'b0;
          end else if (expired) begin
            drop  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + cnt_w'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prll_bs_rbtr_rr_n_drvrs.sv
// Scoreboard bench: FIFO environment, transaction model, event monitor.
// Directed scenarios followed by randomized traffic and backpressure.
module tb_prll_bs_rbtr_rr_n_drvrs;

  localparam int B = 256;
  localparam int N = 6;
  localparam int T = 16;

  typedef logic [B-1:0] pkt_t;
  typedef struct {
    int           cyc;
    logic [N-1:0] pop;
    logic [N-1:0] push;
    logic         drop;
    pkt_t         data;
  } ev_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   pndng;
  logic [N-1:0]   full;
  logic [N*B-1:0] D_pop;
  logic [N-1:0]   pop;
  logic [N-1:0]   push;
  logic [N*B-1:0] D_push;
  logic           drop;
  logic           busy;

  prll_bs_rbtr_rr_n_drvrs #(
    .bits(B), .drvrs(N), .id_w(8),
    .broadcast(8'hFF), .timeout(T)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng),
    .D_pop(D_pop), .full(full), .pop(pop),
    .push(push), .D_push(D_push), .drop(drop),
    .busy(busy)
  );

  always #5 clk = ~clk;

  pkt_t eq[N][$];
  pkt_t mq[N][$];
  ev_t  expq[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic         rst_v = 1'b0;
  logic [N-1:0] full_v = '0;
  logic         mon_on = 1'b0;
  logic         exp_busy = 1'b0;
  logic         m_hold = 1'b0;
  pkt_t         m_pkt;
  int           m_src = 0;
  int           m_last = N - 1;
  int           m_stall = 0;
  int           ri;

  function automatic pkt_t mk(logic [7:0] d);
    pkt_t p;
    for (int k = 0; k < B / 32; k++) p[k*32 +: 32] = $urandom;
    p[B-1 -: 8] = d;
    return p;
  endfunction

  function automatic logic [7:0] rdest();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 8'($urandom_range(0, N - 1));
    if (r < 8) return 8'hFF;
    return 8'($urandom_range(N, 254));
  endfunction

  task automatic load(int i, logic [7:0] d);
    pkt_t p;
    p = mk(d);
    eq[i].push_back(p);
    mq[i].push_back(p);
  endtask

  // Reference: one packet in flight, round-robin from the last grant.
  task automatic model_step();
    ev_t          e;
    logic [N-1:0] tgt;
    logic [7:0]   d;
    logic         got;
    int           i;
    cyc++;
    e.cyc = cyc;
    e.pop = '0;
    e.push = '0;
    e.drop = 1'b0;
    e.data = '0;
    if (!rst_v) begin
      m_hold = 1'b0;
      m_last = N - 1;
      m_stall = 0;
    end else if (!m_hold) begin
      got = 1'b0;
      for (int k = 1; k <= N; k++) begin
        i = (m_last + k) % N;
        if (!got && mq[i].size() > 0) begin
          got = 1'b1;
          m_pkt = mq[i].pop_front();
          m_src = i;
          m_last = i;
          m_stall = 0;
          m_hold = 1'b1;
          e.pop[i] = 1'b1;
        end
      end
    end else begin
      d = m_pkt[B-1 -: 8];
      tgt = '0;
      if (d == 8'hFF) begin
        tgt = '1;
        tgt[m_src] = 1'b0;
      end else if (d < N) begin
        tgt = N'(1) << d;
      end
      if (tgt == '0) begin
        e.drop = 1'b1;
        m_hold = 1'b0;
      end else if ((tgt & full_v) == '0) begin
        e.push = tgt;
        e.data = m_pkt;
        m_hold = 1'b0;
      end else begin
        m_stall++;
        if (m_stall == T) begin
          e.drop = 1'b1;
          m_hold = 1'b0;
        end
      end
    end
    exp_busy = m_hold;
    if (e.pop != '0 || e.push != '0 || e.drop) expq.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (pop[i] === 1'b1 && eq[i].size() > 0) void'(eq[i].pop_front());
    end
    for (int i = 0; i < N; i++) begin
      pndng[i] = (eq[i].size() > 0);
      D_pop[i*B +: B] = (eq[i].size() > 0) ? eq[i][0] : '0;
    end
    full = full_v;
    reset = rst_v;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor: busy every cycle, event records whenever the DUT acts.
  initial begin
    ev_t e;
    int  bad;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        compared++;
        if (busy !== exp_busy) begin
          mismatched++;
          $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
        end
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
          e = expq.pop_front();
          compared++;
          mismatched++;
          $display("FAIL missed cyc=%0d: got none want pop=%b push=%b drop=%b",
                   e.cyc, e.pop, e.push, e.drop);
        end
        if (pop !== '0 || push !== '0 || drop !== 1'b0) begin
          compared++;
          if (expq.size() == 0 || expq[0].cyc != cyc) begin
            mismatched++;
            $display("FAIL unexpected cyc=%0d: got pop=%b push=%b drop=%b want none",
                     cyc, pop, push, drop);
          end else begin
            e = expq.pop_front();
            if (pop !== e.pop || push !== e.push || drop !== e.drop) begin
              mismatched++;
              $display("FAIL event cyc=%0d: got pop=%b push=%b drop=%b want pop=%b push=%b drop=%b",
                       cyc, pop, push, drop, e.pop, e.push, e.drop);
            end
            if (e.push != '0) begin
              compared++;
              bad = -1;
              for (int s = 0; s < N; s++) begin
                if (bad < 0 && D_push[s*B +: B] !== e.data) bad = s;
              end
              if (bad >= 0) begin
                mismatched++;
                $display("FAIL data cyc=%0d slice %0d: got %0h want %0h",
                         cyc, bad, D_push[bad*B +: B], e.data);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    pndng = '0;
    full = '0;
    D_pop = '0;
    rst_v = 1'b0;
    idle(3);
    mon_on = 1'b1;
    #2;
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_push", 64'(push), 64'd0);
    chk("rst_dpush", 64'(|D_push), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_v = 1'b1;
    idle(2);

    load(2, 8'd4);
    idle(4);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) load(i, 8'($urandom_range(0, N - 1)));
    idle(30);

    load(1, 8'hFF);
    idle(4);
    full_v = 6'b001000;
    load(1, 8'hFF);
    idle(6);
    full_v = '0;
    idle(4);

    load(3, 8'h09);
    idle(4);

    full_v = 6'b000001;
    load(2, 8'h00);
    idle(22);
    full_v = '0;
    load(5, 8'd2);
    idle(5);

    load(4, 8'd1);
    tick();
    rst_v = 1'b0;
    tick();
    #2;
    chk("rstpush_push", 64'(push), 64'd0);
    chk("rstpush_busy", 64'(busy), 64'd0);
    chk("rstpush_dpush", 64'(|D_push), 64'd0);
    rst_v = 1'b1;
    load(3, 8'd5);
    load(0, 8'd3);
    idle(8);

    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        ri = $urandom_range(0, N - 1);
        if (eq[ri].size() < 4) load(ri, rdest());
      end
      for (int i = 0; i < N; i++) full_v[i] = ($urandom_range(0, 4) == 0);
      rst_v = ($urandom_range(0, 249) != 0);
      tick();
    end
    full_v = '0;
    rst_v = 1'b1;
    idle(80);

    chk("drain_expq", 64'(expq.size()), 64'd0);
    for (int i = 0; i < N; i++)
      chk($sformatf("fifo%0d_left", i), 64'(eq[i].size()), 64'(mq[i].size()));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
